// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: decodes alu_ctl, computes the result and issues a one-cycle register-file write.
// Optional macro ALU_MUL_EN builds the iterative shift-add multiplier (alu_ctl 8); otherwise code 8 is illegal.
module alu_writeback_stage #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu_ctl,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    input  logic [REG_W-1:0]  wb_reg_in,
    output logic              wb_en,
    output logic [REG_W-1:0]  wb_reg_out,
    output logic [DATA_W-1:0] wb_data,
    output logic              flag_z,
    output logic              flag_c,
    output logic              busy,
    output logic              illegal_op
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_MOV = 4'd9;
    localparam logic [3:0] OP_NOP = 4'd15;

    // Handshake: an op is taken on a rising edge with in_valid && in_ready;
    // in_ready depends only on registered state, never on in_valid.
    logic accept;

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;
    logic [DATA_W:0] shl_ext;
    logic [DATA_W:0] shr_ext;

    logic [DATA_W-1:0] dec_res;
    logic              dec_c;
    logic              dec_wr;
    logic              dec_ill;

    logic              wb_en_q, wb_en_d;
    logic [REG_W-1:0]  wb_reg_q, wb_reg_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              flag_z_q, flag_z_d;
    logic              flag_c_q, flag_c_d;
    logic              illegal_q, illegal_d;

    assign accept = in_valid && in_ready;

    // One guard bit on each shift catches the last bit shifted out.
    assign sum     = {1'b0, op1} + {1'b0, op2};
    assign diff    = {1'b0, op1} - {1'b0, op2};
    assign shl_ext = {1'b0, op1} << op2[3:0];
    assign shr_ext = {op1, 1'b0} >> op2[3:0];

`ifdef ALU_MUL_EN
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [0:0] {ST_IDLE, ST_MUL} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [2*DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [REG_W-1:0]    dst_q, dst_d;
    logic                busy_q, busy_d;
    logic                dec_mul;
    logic [2*DATA_W-1:0] mul_sum;
    logic                mul_done;

    assign mul_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_done = (state_q == ST_MUL) && (cnt_q == CNT_W'(DATA_W - 1));
    assign in_ready = (state_q == ST_IDLE);
    assign busy     = busy_q;
`else
    assign in_ready = 1'b1;
    assign busy     = 1'b0;
`endif

    always_comb begin
        dec_res = '0;
        dec_c   = 1'b0;
        dec_wr  = 1'b1;
        dec_ill = 1'b0;
`ifdef ALU_MUL_EN
        dec_mul = 1'b0;
`endif
        case (alu_ctl)
            OP_ADD: begin dec_res = sum[DATA_W-1:0];  dec_c = sum[DATA_W];  end
            OP_SUB: begin dec_res = diff[DATA_W-1:0]; dec_c = diff[DATA_W]; end
            OP_AND: dec_res = op1 & op2;
            OP_OR:  dec_res = op1 | op2;
            OP_XOR: dec_res = op1 ^ op2;
            OP_NOT: dec_res = ~op1;
            OP_MOV: dec_res = op2;
            OP_SHL: begin dec_res = shl_ext[DATA_W-1:0]; dec_c = shl_ext[DATA_W]; end
            OP_SHR: begin dec_res = shr_ext[DATA_W:1];   dec_c = shr_ext[0];      end
`ifdef ALU_MUL_EN
            OP_MUL: begin dec_wr = 1'b0; dec_mul = 1'b1; end
`else
            OP_MUL: begin dec_wr = 1'b0; dec_ill = 1'b1; end
`endif
            OP_NOP: dec_wr = 1'b0;
            default: begin dec_wr = 1'b0; dec_ill = 1'b1; end
        endcase
    end

    always_comb begin
        wb_en_d   = 1'b0;
        wb_reg_d  = wb_reg_q;
        wb_data_d = wb_data_q;
        flag_z_d  = flag_z_q;
        flag_c_d  = flag_c_q;
        illegal_d = 1'b0;
        if (accept) begin
            illegal_d = dec_ill;
            if (dec_wr) begin
                wb_en_d   = 1'b1;
                wb_reg_d  = wb_reg_in;
                wb_data_d = dec_res;
                flag_z_d  = (dec_res == '0);
                flag_c_d  = dec_c;
            end
        end
`ifdef ALU_MUL_EN
        if (mul_done) begin
            wb_en_d   = 1'b1;
            wb_reg_d  = dst_q;
            wb_data_d = mul_sum[DATA_W-1:0];
            flag_z_d  = (mul_sum[DATA_W-1:0] == '0);
            flag_c_d  = (mul_sum[2*DATA_W-1:DATA_W] != '0);
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en_q   <= 1'b0;
            wb_reg_q  <= '0;
            wb_data_q <= '0;
            flag_z_q  <= 1'b0;
            flag_c_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            wb_en_q   <= wb_en_d;
            wb_reg_q  <= wb_reg_d;
            wb_data_q <= wb_data_d;
            flag_z_q  <= flag_z_d;
            flag_c_q  <= flag_c_d;
            illegal_q <= illegal_d;
        end
    end

`ifdef ALU_MUL_EN
    // Shift-add: multiplicand moves left, multiplier moves right, one bit per cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        dst_d    = dst_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && dec_mul) begin
                    state_d  = ST_MUL;
                    cnt_d    = '0;
                    acc_d    = '0;
                    mcand_d  = {{DATA_W{1'b0}}, op1};
                    mplier_d = op2;
                    dst_d    = wb_reg_in;
                end
            end
            default: begin
                acc_d    = mul_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (mul_done) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
        endcase
        busy_d = (state_d == ST_MUL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            dst_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            dst_q    <= dst_d;
            busy_q   <= busy_d;
        end
    end
`endif

    assign wb_en      = wb_en_q;
    assign wb_reg_out = wb_reg_q;
    assign wb_data    = wb_data_q;
    assign flag_z     = flag_z_q;
    assign flag_c     = flag_c_q;
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Bench for alu_writeback_stage: directed cases plus random ops checked by a scoreboard
// fed from an arithmetic reference model; covers both builds of ALU_MUL_EN.
module tb_alu_writeback_stage;

  localparam int W  = 16;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    alu_ctl = 4'd15;
  logic [W-1:0]  op1 = '0;
  logic [W-1:0]  op2 = '0;
  logic [RW-1:0] wb_reg_in = '0;
  logic          wb_en;
  logic [RW-1:0] wb_reg_out;
  logic [W-1:0]  wb_data;
  logic          flag_z;
  logic          flag_c;
  logic          busy;
  logic          illegal_op;

  alu_writeback_stage #(.DATA_W(W), .REG_W(RW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctl(alu_ctl), .op1(op1), .op2(op2), .wb_reg_in(wb_reg_in),
    .wb_en(wb_en), .wb_reg_out(wb_reg_out), .wb_data(wb_data),
    .flag_z(flag_z), .flag_c(flag_c), .busy(busy), .illegal_op(illegal_op)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  // entry layout: {illegal, reg[3:0], data[15:0], z, c}
  logic [22:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  logic m_z = 1'b0;
  logic m_c = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: results straight from the opcode definitions.
  task automatic push_expected(input logic [3:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [RW-1:0] rg);
    int unsigned sh;
    longint unsigned wide;
    logic [W-1:0] r;
    logic c;
    bit wr;
    bit ill;
    sh = int'(b[3:0]);
    r = '0;
    c = 1'b0;
    wr = 1'b1;
    ill = 1'b0;
    case (ctl)
      4'd0: begin wide = longint'(a) + longint'(b); r = W'(wide); c = (wide > 64'hFFFF); end
      4'd1: begin r = a - b; c = (a < b); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd9: r = b;
      4'd6: begin r = a << sh; c = (sh == 0) ? 1'b0 : a[W - sh]; end
      4'd7: begin r = a >> sh; c = (sh == 0) ? 1'b0 : a[sh - 1]; end
`ifdef ALU_MUL_EN
      4'd8: begin wide = longint'(a) * longint'(b); r = W'(wide); c = (wide >= 64'h10000); end
`endif
      4'd15: wr = 1'b0;
      default: begin wr = 1'b0; ill = 1'b1; end
    endcase
    if (ill) begin
      exp_q.push_back({1'b1, 4'd0, 16'd0, m_z, m_c});
    end else if (wr) begin
      m_z = (r == 0);
      m_c = c;
      exp_q.push_back({1'b0, rg, r, m_z, m_c});
    end
  endtask

  // Monitor: pops one expected entry per write strobe or illegal pulse.
  always @(negedge clk) begin
    logic [22:0] e;
    if (!rst && (wb_en || illegal_op)) begin
      if (wb_en && illegal_op) begin
        chk("wb_and_illegal_together", 32'd1, 32'd0);
      end else if (exp_q.size() == 0) begin
        chk("unexpected_output", {30'd0, wb_en, illegal_op}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_kind_illegal", 32'(illegal_op), 32'(e[22]));
        if (wb_en) begin
          chk("sb_wb_reg", 32'(wb_reg_out), 32'(e[21:18]));
          chk("sb_wb_data", 32'(wb_data), 32'(e[17:2]));
        end
        chk("sb_flag_z", 32'(flag_z), 32'(e[1]));
        chk("sb_flag_c", 32'(flag_c), 32'(e[0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called between edges; returns at the negedge after acceptance with in_valid low.
  task automatic send(input logic [3:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [RW-1:0] rg);
    int n;
    n = 0;
    in_valid = 1'b1;
    alu_ctl = ctl;
    op1 = a;
    op2 = b;
    wb_reg_in = rg;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    push_expected(ctl, a, b, rg);
    @(negedge clk);
    in_valid = 1'b0;
    op1 = 16'($urandom());
    op2 = 16'($urandom());
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 16'hFFFF;
      2: return 16'($urandom_range(0, 15));
      default: return 16'($urandom());
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int cnt;
    repeat (3) @(negedge clk);
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_wb_reg", 32'(wb_reg_out), 32'd0);
    chk("rst_wb_data", 32'(wb_data), 32'd0);
    chk("rst_flags", {30'd0, flag_z, flag_c}, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_illegal", 32'(illegal_op), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(in_ready), 32'd1);

    // ADD then SUB back-to-back
    send(4'd0, 16'hFFFF, 16'h0001, 4'd3);
    #1;
    chk("add_wb", {wb_en, 3'd0, wb_reg_out, wb_data, 6'd0, flag_z, flag_c}, {1'b1, 3'd0, 4'd3, 16'h0000, 6'd0, 1'b1, 1'b1});
    send(4'd1, 16'h0005, 16'h0007, 4'd4);
    #1;
    chk("sub_wb", {wb_en, 3'd0, wb_reg_out, wb_data, 6'd0, flag_z, flag_c}, {1'b1, 3'd0, 4'd4, 16'hFFFE, 6'd0, 1'b0, 1'b1});
    idle(1);
    chk("wb_en_drops", 32'(wb_en), 32'd0);
    chk("wb_data_holds", 32'(wb_data), 32'h0000FFFE);

    // shifts
    send(4'd6, 16'h8001, 16'h0001, 4'd1);
    #1;
    chk("shl1", {15'd0, wb_data, flag_c}, {15'd0, 16'h0002, 1'b1});
    send(4'd6, 16'h1234, 16'h0000, 4'd2);
    #1;
    chk("shl0", {15'd0, wb_data, flag_c}, {15'd0, 16'h1234, 1'b0});
    send(4'd7, 16'h0001, 16'h0001, 4'd5);
    #1;
    chk("shr1", {14'd0, wb_data, flag_z, flag_c}, {14'd0, 16'h0000, 1'b1, 1'b1});

    // NOP then illegal 12: flags keep Z=1, C=1
    send(4'd15, 16'h1111, 16'h2222, 4'd6);
    #1;
    chk("nop_outputs", {28'd0, wb_en, illegal_op, flag_z, flag_c}, 32'b0011);
    send(4'd12, 16'h1111, 16'h2222, 4'd6);
    #1;
    chk("ill12_outputs", {28'd0, wb_en, illegal_op, flag_z, flag_c}, 32'b0111);
    idle(1);
    chk("ill12_one_pulse", 32'(illegal_op), 32'd0);

`ifdef ALU_MUL_EN
    send(4'd8, 16'h0100, 16'h0100, 4'd7);
    #1;
    chk("mul_busy", {30'd0, busy, in_ready}, 32'b10);
    cnt = 0;
    while (!in_ready && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    #1;
    chk("mul_ready_low_cycles", 32'(cnt), 32'd16);
    chk("mul_wb", {wb_en, busy, 2'd0, wb_reg_out, wb_data, 6'd0, flag_z, flag_c}, {1'b1, 1'b0, 2'd0, 4'd7, 16'h0000, 6'd0, 1'b1, 1'b1});
    send(4'd8, 16'd3, 16'd5, 4'd8);
    cnt = 0;
    while (!wb_en && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    #1;
    chk("mul3x5", {15'd0, wb_data, flag_c}, {15'd0, 16'h000F, 1'b0});

    // reset 5 cycles into a MUL: aborted, no write
    send(4'd8, 16'h1234, 16'h5678, 4'd9);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mul_abort_outputs", {30'd0, busy, wb_en}, 32'd0);
    exp_q.delete();
    m_z = 1'b0;
    m_c = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    #1;
    chk("mul_abort_ready", {30'd0, in_ready, busy}, 32'b10);
`else
    send(4'd8, 16'd3, 16'd5, 4'd7);
    #1;
    chk("mul_illegal", {29'd0, wb_en, illegal_op, busy}, 32'b010);
`endif

    // reset mid-stream while wb_en is high
    send(4'd3, 16'h00F0, 16'h0F00, 4'd10);
    #2;
    chk("pre_rst_wb_en", 32'(wb_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_outputs", {wb_en, wb_reg_out, wb_data, flag_z, flag_c, busy, illegal_op}, 32'd0);
    exp_q.delete();
    m_z = 1'b0;
    m_c = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_midrst", 32'(in_ready), 32'd1);

    // random traffic against the reference model
    for (int i = 0; i < 200; i++) begin
      send(4'($urandom_range(0, 15)), rand_op(), rand_op(), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    // drain
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 60) begin
      cnt++;
      @(negedge clk);
    end
    idle(2);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
